// File: rtl/vga_timing_pipe_pkg.sv
// Shared VGA timing definitions: standard 640x480@60 numbers, the sync-bundle
// type carried down the delay line, and helpers for totals and idle levels.
package vga_timing_pipe_pkg;

    localparam int STD_H_DISPLAY = 640;
    localparam int STD_H_FP      = 16;
    localparam int STD_H_SYNC    = 96;
    localparam int STD_H_BP      = 48;
    localparam int STD_V_DISPLAY = 480;
    localparam int STD_V_FP      = 10;
    localparam int STD_V_SYNC    = 2;
    localparam int STD_V_BP      = 33;

    // Pin-level view of one pixel position: hs/vs already carry the polarity.
    typedef struct packed {
        logic vid;
        logic hs;
        logic vs;
    } sync_t;

    localparam int SYNC_W = $bits(sync_t);

    function automatic int line_total(input int disp, input int fp, input int sync, input int bp);
        return disp + fp + sync + bp;
    endfunction

    function automatic sync_t inactive_sync(input logic hs_pol, input logic vs_pol);
        sync_t s;
        s.vid = 1'b0;
        s.hs  = ~hs_pol;
        s.vs  = ~vs_pol;
        return s;
    endfunction

endpackage

// File: rtl/vga_sig_delay.sv
// Enable-gated shift register for the sync/video bundle. Exposes the last stage
// and one bit of the stage before it (the value o_q will hold one enable later).
module vga_sig_delay #(
    parameter int             WIDTH   = 3,
    parameter int             DEPTH   = 1,
    parameter int             PRE_BIT = WIDTH - 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_pre_bit
);

    logic [DEPTH*WIDTH-1:0] r_sh;
    logic [DEPTH*WIDTH-1:0] w_next;

    // Newest stage sits in the low bits; the oldest is at the top.
    generate
        if (DEPTH == 1) begin : g_one
            assign w_next    = i_d;
            assign o_pre_bit = i_d[PRE_BIT];
        end else begin : g_many
            assign w_next    = {r_sh[(DEPTH-1)*WIDTH-1:0], i_d};
            assign o_pre_bit = r_sh[(DEPTH-2)*WIDTH + PRE_BIT];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh <= {DEPTH{INIT}};
        end else if (i_en) begin
            r_sh <= w_next;
        end
    end

    assign o_q = r_sh[(DEPTH-1)*WIDTH +: WIDTH];

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA timing generator: pixel divider, h/v counters, sync decode, and a delay
// line that keeps sync/video aligned with a graphics unit of PIPE_DLY ticks.
module vga_timing_pipe
    import vga_timing_pipe_pkg::*;
#(
    parameter int   H_DISPLAY = STD_H_DISPLAY,
    parameter int   H_FP      = STD_H_FP,
    parameter int   H_SYNC    = STD_H_SYNC,
    parameter int   H_BP      = STD_H_BP,
    parameter int   V_DISPLAY = STD_V_DISPLAY,
    parameter int   V_FP      = STD_V_FP,
    parameter int   V_SYNC    = STD_V_SYNC,
    parameter int   V_BP      = STD_V_BP,
    parameter int   DIV       = 2,
    parameter int   PIPE_DLY  = 0,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   CW        = 10,
    parameter int   RGB_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [CW-1:0]    pixel_x,
    output logic [CW-1:0]    pixel_y,
    output logic             p_tick,
    output logic             frame_start,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb_out
);

    localparam int H_TOTAL = line_total(H_DISPLAY, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_DISPLAY, V_FP, V_SYNC, V_BP);
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    // Decode bounds carry one spare bit so a sync ending exactly at the total still fits.
    localparam logic [CW:0] H_VIS = (CW+1)'(H_DISPLAY);
    localparam logic [CW:0] H_SS  = (CW+1)'(H_DISPLAY + H_FP);
    localparam logic [CW:0] H_SE  = (CW+1)'(H_DISPLAY + H_FP + H_SYNC);
    localparam logic [CW:0] V_VIS = (CW+1)'(V_DISPLAY);
    localparam logic [CW:0] V_SS  = (CW+1)'(V_DISPLAY + V_FP);
    localparam logic [CW:0] V_SE  = (CW+1)'(V_DISPLAY + V_FP + V_SYNC);

    localparam sync_t SYNC_IDLE = inactive_sync(HS_POL, VS_POL);

    logic [DW-1:0]    r_div_cnt;
    logic [CW-1:0]    r_h_cnt;
    logic [CW-1:0]    r_v_cnt;
    logic [RGB_W-1:0] r_rgb;

    logic             w_tick;
    logic [CW:0]      w_h;
    logic [CW:0]      w_v;
    sync_t            w_dec;
    sync_t            w_q;
    logic             w_vid_pre;

    assign w_tick = (r_div_cnt == DIV_LAST) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_tick) begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    assign w_h = {1'b0, r_h_cnt};
    assign w_v = {1'b0, r_v_cnt};

    always_comb begin
        w_dec     = SYNC_IDLE;
        w_dec.vid = (w_h < H_VIS) && (w_v < V_VIS);
        if (w_h >= H_SS && w_h < H_SE) begin
            w_dec.hs = HS_POL;
        end
        if (w_v >= V_SS && w_v < V_SE) begin
            w_dec.vs = VS_POL;
        end
    end

    vga_sig_delay #(
        .WIDTH   (SYNC_W),
        .DEPTH   (PIPE_DLY + 1),
        .PRE_BIT (SYNC_W - 1),
        .INIT    (SYNC_IDLE)
    ) u_sig_delay (
        .clk       (clk),
        .reset     (reset),
        .i_en      (w_tick),
        .i_d       (w_dec),
        .o_q       (w_q),
        .o_pre_bit (w_vid_pre)
    );

    // rgb_in belongs to the pixel decoded PIPE_DLY ticks ago; blank it by that stage's flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb <= '0;
        end else if (w_tick) begin
            r_rgb <= w_vid_pre ? rgb_in : '0;
        end
    end

    assign pixel_x     = r_h_cnt;
    assign pixel_y     = r_v_cnt;
    assign p_tick      = w_tick;
    assign frame_start = w_tick && (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
    assign video_on    = w_q.vid;
    assign hsync       = w_q.hs;
    assign vsync       = w_q.vs;
    assign rgb_out     = r_rgb;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: three small-timing instances (DIV/PIPE_DLY/polarity
// variants) checked every clock against a tick-index reference model.
module tb_vga_timing_pipe;

    localparam int HD = 8, HFP = 2, HSW = 3, HBP = 1, HT = 14;
    localparam int VD = 4, VFP = 1, VSW = 1, VBP = 1, VT = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [2:0] rgb_in [3];
    logic [3:0] px [3];
    logic [3:0] py [3];
    logic [2:0] rgb_o [3];
    logic [2:0] tick, fs, vid, hs, vs;

    int checks = 0;
    int errors = 0;

    int   cyc [3];
    int   tk [3];
    bit   started [3];
    bit   pend [3];
    logic [2:0] last_rgb [3];

    vga_timing_pipe #(.H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .DIV(2), .PIPE_DLY(0),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .RGB_W(3)) u_a (
        .clk(clk), .reset(rst[0]), .rgb_in(rgb_in[0]), .pixel_x(px[0]), .pixel_y(py[0]),
        .p_tick(tick[0]), .frame_start(fs[0]), .video_on(vid[0]), .hsync(hs[0]),
        .vsync(vs[0]), .rgb_out(rgb_o[0]));

    vga_timing_pipe #(.H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .DIV(2), .PIPE_DLY(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .RGB_W(3)) u_b (
        .clk(clk), .reset(rst[1]), .rgb_in(rgb_in[1]), .pixel_x(px[1]), .pixel_y(py[1]),
        .p_tick(tick[1]), .frame_start(fs[1]), .video_on(vid[1]), .hsync(hs[1]),
        .vsync(vs[1]), .rgb_out(rgb_o[1]));

    vga_timing_pipe #(.H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .DIV(1), .PIPE_DLY(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .RGB_W(3)) u_c (
        .clk(clk), .reset(rst[2]), .rgb_in(rgb_in[2]), .pixel_x(px[2]), .pixel_y(py[2]),
        .p_tick(tick[2]), .frame_start(fs[2]), .video_on(vid[2]), .hsync(hs[2]),
        .vsync(vs[2]), .rgb_out(rgb_o[2]));

    function automatic int div_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic int pipe_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
    endfunction

    function automatic logic pol_of(input int i);
        return (i == 2);
    endfunction

    // Position shown by the counters after t pixel ticks since reset.
    function automatic int hpos(input int t);
        return t % HT;
    endfunction

    function automatic int vpos(input int t);
        return (t / HT) % VT;
    endfunction

    function automatic logic vis(input int j);
        return (hpos(j) < HD) && (vpos(j) < VD);
    endfunction

    function automatic logic hact(input int j);
        return (hpos(j) >= HD + HFP) && (hpos(j) < HD + HFP + HSW);
    endfunction

    function automatic logic vact(input int j);
        return (vpos(j) >= VD + VFP) && (vpos(j) < VD + VFP + VSW);
    endfunction

    // Each clock: compare every running instance against the model at negedge,
    // drive the graphics colour for the coming edge, then advance the model.
    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                logic etick, evid, ehs, evs, efs, pol;
                logic [2:0] ergb, nrgb;
                logic [15:0] ev, ov;
                int t, j;
                etick = 1'b0;
                if (started[i]) begin
                    t     = tk[i];
                    pol   = pol_of(i);
                    etick = !rst[i] && ((cyc[i] % div_of(i)) == div_of(i) - 1);
                    j     = t - 1 - pipe_of(i);
                    evid  = (j >= 0) && vis(j);
                    ehs   = ((j >= 0) && hact(j)) ? pol : !pol;
                    evs   = ((j >= 0) && vact(j)) ? pol : !pol;
                    ergb  = evid ? last_rgb[i] : 3'd0;
                    efs   = etick && hpos(t) == HT - 1 && vpos(t) == VT - 1;
                    ev = {etick, efs, evid, ehs, evs, ergb, 4'(hpos(t)), 4'(vpos(t))};
                    ov = {tick[i], fs[i], vid[i], hs[i], vs[i], rgb_o[i], px[i], py[i]};
                    checks++;
                    if (ov !== ev) begin
                        errors++;
                        if (errors <= 30)
                            $display("FAIL model inst%0d t=%0d {tick,fs,vid,hs,vs,rgb,x,y}: got %h expected %h",
                                     i, t, ov, ev);
                    end
                end
                pend[i] = etick;
                case (i)
                    0:       nrgb = 3'($urandom);
                    1:       nrgb = (tk[1] >= 2) ? 3'(hpos(tk[1] - 2)) : 3'd0;
                    default: nrgb = 3'b111;
                endcase
                rgb_in[i] = nrgb;
                if (etick) last_rgb[i] = nrgb;
            end
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst[i]) begin
                    started[i] = 1'b1;
                    cyc[i] = 0;
                    tk[i] = 0;
                end else if (started[i]) begin
                    if (pend[i]) tk[i]++;
                    cyc[i]++;
                end
            end
            #1;
        end
    endtask

    task automatic test_reset();
        logic [15:0] got;
        rst = 3'b111;
        run_cycles(3);
        got = {px[0], py[0], rgb_o[0], vid[0], hs[0], vs[0], tick[0], fs[0]};
        checks++;
        if (got !== 16'b0000_0000_000_0_1_1_0_0) begin
            errors++;
            $display("FAIL reset_a {x,y,rgb,vid,hs,vs,tick,fs}: got %b expected 0000000000001100", got);
        end
        checks++;
        if ({hs[2], vs[2], vid[2], rgb_o[2]} !== 6'b0) begin
            errors++;
            $display("FAIL reset_c_pol {hs,vs,vid,rgb}: got %b expected 000000", {hs[2], vs[2], vid[2], rgb_o[2]});
        end
        rst = 3'b000;
        #1;
        checks++;
        if ({tick[0], tick[2]} !== 2'b01) begin
            errors++;
            $display("FAIL release_tick {a,c}: got %b expected 01", {tick[0], tick[2]});
        end
        run_cycles(1);
        checks++;
        if (tick[0] !== 1'b1) begin
            errors++;
            $display("FAIL first_tick_a: got %b expected 1", tick[0]);
        end
    endtask

    task automatic test_hsync_a();
        int lows, gap, budget;
        logic prev;
        run_cycles(20);
        lows = 0;
        for (int k = 0; k < 28; k++) begin
            run_cycles(1);
            if (hs[0] === 1'b0) lows++;
        end
        checks++;
        if (lows != 6) begin
            errors++;
            $display("FAIL hsync_low_clks: got %0d expected 6", lows);
        end
        prev = hs[0];
        budget = 0;
        while (!(prev === 1'b1 && hs[0] === 1'b0) && budget < 80) begin
            prev = hs[0];
            run_cycles(1);
            budget++;
        end
        checks++;
        if (budget >= 80 || px[0] !== 4'd11) begin
            errors++;
            $display("FAIL hsync_fall_x: got x=%0d (budget %0d) expected 11", px[0], budget);
        end
        budget = 0;
        while (fs[0] !== 1'b1 && budget < 400) begin
            run_cycles(1);
            budget++;
        end
        gap = 0;
        do begin
            run_cycles(1);
            gap++;
        end while (fs[0] !== 1'b1 && gap < 400);
        checks++;
        if (budget >= 400 || gap != 196) begin
            errors++;
            $display("FAIL frame_start_period_a: got %0d expected 196", gap);
        end
    endtask

    task automatic test_pipe_b();
        logic prev_tick, prev_vid, synced;
        int cnt, lines;
        prev_tick = 1'b0;
        prev_vid = 1'b0;
        synced = 1'b0;
        cnt = 0;
        lines = 0;
        for (int k = 0; k < 420; k++) begin
            run_cycles(1);
            if (prev_tick) begin
                if (vid[1] === 1'b1) begin
                    if (synced) begin
                        checks++;
                        if (rgb_o[1] !== 3'(cnt)) begin
                            errors++;
                            $display("FAIL pipe_rgb line-pos %0d: got %0d expected %0d", cnt, rgb_o[1], cnt);
                        end
                    end
                    cnt++;
                end else if (prev_vid) begin
                    if (synced) begin
                        lines++;
                        checks++;
                        if (cnt != 8) begin
                            errors++;
                            $display("FAIL pipe_visible_ticks: got %0d expected 8", cnt);
                        end
                    end
                    synced = 1'b1;
                    cnt = 0;
                end
                prev_vid = vid[1];
            end
            prev_tick = tick[1];
        end
        checks++;
        if (lines < 4) begin
            errors++;
            $display("FAIL pipe_lines_seen: got %0d expected at least 4", lines);
        end
    endtask

    task automatic test_blank_c();
        for (int k = 0; k < 120; k++) begin
            run_cycles(1);
            checks++;
            if (rgb_o[2] !== (vid[2] ? 3'b111 : 3'b000)) begin
                errors++;
                $display("FAIL blank_c vid=%b: got %b expected %b", vid[2], rgb_o[2], vid[2] ? 3'b111 : 3'b000);
            end
        end
    endtask

    task automatic test_div1_c();
        int ticks, hhi, vhi, gap, budget;
        logic prev;
        ticks = 0;
        for (int k = 0; k < 40; k++) begin
            run_cycles(1);
            if (tick[2] === 1'b1) ticks++;
        end
        checks++;
        if (ticks != 40) begin
            errors++;
            $display("FAIL div1_ticks: got %0d expected 40", ticks);
        end
        hhi = 0;
        for (int k = 0; k < 14; k++) begin
            run_cycles(1);
            if (hs[2] === 1'b1) hhi++;
        end
        checks++;
        if (hhi != 3) begin
            errors++;
            $display("FAIL hsync_high_ticks_c: got %0d expected 3", hhi);
        end
        vhi = 0;
        for (int k = 0; k < 98; k++) begin
            run_cycles(1);
            if (vs[2] === 1'b1) vhi++;
        end
        checks++;
        if (vhi != 14) begin
            errors++;
            $display("FAIL vsync_high_ticks_c: got %0d expected 14", vhi);
        end
        prev = vs[2];
        budget = 0;
        while (!(prev === 1'b0 && vs[2] === 1'b1) && budget < 200) begin
            prev = vs[2];
            run_cycles(1);
            budget++;
        end
        checks++;
        if (budget >= 200 || py[2] !== 4'd5) begin
            errors++;
            $display("FAIL vsync_rise_y_c: got y=%0d (budget %0d) expected 5", py[2], budget);
        end
        budget = 0;
        while (fs[2] !== 1'b1 && budget < 200) begin
            run_cycles(1);
            budget++;
        end
        gap = 0;
        do begin
            run_cycles(1);
            gap++;
        end while (fs[2] !== 1'b1 && gap < 200);
        checks++;
        if (budget >= 200 || gap != 98) begin
            errors++;
            $display("FAIL frame_start_period_c: got %0d expected 98", gap);
        end
    endtask

    task automatic test_reset_mid();
        int budget;
        logic [12:0] got;
        budget = 0;
        while (!(px[0] === 4'd5 && py[0] === 4'd2) && budget < 400) begin
            run_cycles(1);
            budget++;
        end
        checks++;
        if (budget >= 400) begin
            errors++;
            $display("FAIL reach_h5_v2: got x=%0d y=%0d expected 5,2", px[0], py[0]);
        end
        rst[0] = 1'b1;
        run_cycles(1);
        rst[0] = 1'b0;
        #1;
        got = {px[0], py[0], rgb_o[0], hs[0], vs[0]};
        checks++;
        if (got !== 13'b0000_0000_000_1_1) begin
            errors++;
            $display("FAIL mid_reset {x,y,rgb,hs,vs}: got %b expected 0000000000011", got);
        end
        checks++;
        if (tick[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_tick_clk1: got %b expected 0", tick[0]);
        end
        run_cycles(1);
        checks++;
        if (tick[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_tick_clk2: got %b expected 1", tick[0]);
        end
        run_cycles(300);
    endtask

    initial begin
        rst = 3'b111;
        for (int i = 0; i < 3; i++) begin
            rgb_in[i] = 3'd0;
            cyc[i] = 0;
            tk[i] = 0;
            started[i] = 1'b0;
            pend[i] = 1'b0;
            last_rgb[i] = 3'd0;
        end
        test_reset();
        test_hsync_a();
        test_pipe_b();
        test_blank_c();
        test_div1_c();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
